// File: rtl/rec_dados_i2c.sv
// -----------------------------------------------------------------------------
// rec_dados_i2c
//
// Receive stage that follows the I2C address decoder. After the decoder
// pulses `escrita` (address matched, write), this block:
//   - drives the address ACK on SDA,
//   - takes the first data byte as the register pointer,
//   - turns each following byte into a one-cycle register-bank write.
// It watches raw SDA/SCL itself and abandons the transfer on STOP or
// repeated START.
//
// Optional build macro:
//   REC_DADOS_AUTOINC_EN  defined   : pointer advances after each accepted
//                                     data byte (burst writes consecutive
//                                     registers).
//                         undefined : pointer stays fixed; every data byte
//                                     in the transfer writes the same
//                                     register.
//
// Parameters:
//   ADDR_W    width of the register pointer / reg_addr
//   NUM_REGS  implemented registers; pointer >= NUM_REGS is out of range
//
// Ports:
//   clk       system clock
//   reset     asynchronous reset, active low
//   sda, scl  raw I2C lines (asynchronous to clk)
//   escrita   one-cycle pulse from the decoder: address match + write
//   reg_addr  write address to the register bank (held between strobes)
//   reg_dado  write data to the register bank (held between strobes)
//   reg_we    one-cycle write strobe
//   sda_puxa  1 = pull SDA low (ACK); open-drain pad lives outside
//   ocupado   high whenever the FSM is not IDLE
//   erro      one-cycle pulse when an out-of-range access is NACKed
// -----------------------------------------------------------------------------
module rec_dados_i2c #(
   parameter int ADDR_W   = 8,
   parameter int NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sda,
   input  logic              scl,
   input  logic              escrita,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_dado,
   output logic              reg_we,
   output logic              sda_puxa,
   output logic              ocupado,
   output logic              erro
);

   typedef enum logic [2:0] {
      IDLE,
      ACK_ESPERA,
      ACK_PUXA,
      ACK_FIM,
      RX
   } estado_t;

   // ---------------------------------------------------------------------------
   // Input conditioning.
   // Each line runs through a 3-deep shift: [0],[1] form the 2-FF
   // synchronizer (s_x = [1]), [2] is the extra delay (s_x_d). All flops
   // reset to 1 so an idle bus produces no spurious edge after reset.
   // ---------------------------------------------------------------------------
   logic [2:0] scl_pipe;
   logic [2:0] sda_pipe;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_pipe <= '1;
         sda_pipe <= '1;
      end else begin
         scl_pipe <= {scl_pipe[1:0], scl};
         sda_pipe <= {sda_pipe[1:0], sda};
      end
   end

   logic s_scl, s_scl_d, s_sda, s_sda_d;
   logic rise, fall, start, stop;

   assign s_scl   = scl_pipe[1];
   assign s_scl_d = scl_pipe[2];
   assign s_sda   = sda_pipe[1];
   assign s_sda_d = sda_pipe[2];

   assign rise  =  s_scl & ~s_scl_d;
   assign fall  = ~s_scl &  s_scl_d;
   assign start =  s_scl &  s_sda_d & ~s_sda;
   assign stop  =  s_scl & ~s_sda_d &  s_sda;

   // ---------------------------------------------------------------------------
   // Receive datapath
   // ---------------------------------------------------------------------------
   estado_t           estado;
   logic [2:0]        cnt;        // bits received in the current byte
   logic              primeiro;   // next complete byte is the pointer
   logic [ADDR_W-1:0] ptr;
   logic [7:0]        shift;
   logic [7:0]        byte_nxt;   // byte as it will be after this rise

   assign byte_nxt = {shift[6:0], s_sda};

   // The pointer byte is checked on its full 8 bits so that a narrow
   // ADDR_W cannot alias an out-of-range value into range.
   logic byte_ok, ptr_ok;

   assign byte_ok = (32'(byte_nxt) < 32'(NUM_REGS));
   assign ptr_ok  = (32'(ptr)      < 32'(NUM_REGS));

   logic abort;    // START/STOP while a transfer is in progress

   assign abort = (estado != IDLE) && (start || stop);

   // ---------------------------------------------------------------------------
   // Control FSM. All outputs are registered here; reg_we/erro default
   // low every cycle so they can only ever be single-cycle pulses.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado   <= IDLE;
         cnt      <= '0;
         primeiro <= 1'b0;
         ptr      <= '0;
         shift    <= '0;
         reg_addr <= '0;
         reg_dado <= '0;
         reg_we   <= 1'b0;
         sda_puxa <= 1'b0;
         ocupado  <= 1'b0;
         erro     <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         erro   <= 1'b0;

         if (abort) begin
            // Bus condition wins over any edge or byte completion seen in
            // the same cycle; a partial byte is simply dropped.
            estado   <= IDLE;
            cnt      <= '0;
            primeiro <= 1'b0;
            sda_puxa <= 1'b0;
            ocupado  <= 1'b0;
         end else begin
            case (estado)
               IDLE: begin
                  cnt      <= '0;
                  primeiro <= 1'b0;
                  sda_puxa <= 1'b0;
                  // A decoder pulse coinciding with START/STOP belongs to a
                  // transfer that is already over.
                  if (escrita && !start && !stop) begin
                     estado   <= ACK_ESPERA;
                     primeiro <= 1'b1;
                     ocupado  <= 1'b1;
                  end
               end

               // Wait for SCL low after the 8th bit before driving SDA, so
               // the pull never changes SDA while SCL is high.
               ACK_ESPERA: begin
                  if (fall) begin
                     sda_puxa <= 1'b1;
                     estado   <= ACK_PUXA;
                  end
               end

               ACK_PUXA: begin
                  sda_puxa <= 1'b1;
                  if (rise)
                     estado <= ACK_FIM;
               end

               ACK_FIM: begin
                  if (fall) begin
                     sda_puxa <= 1'b0;
                     cnt      <= '0;
                     estado   <= RX;
                  end
               end

               RX: begin
                  if (rise) begin
                     shift <= byte_nxt;
                     if (cnt == 3'd7) begin
                        cnt <= '0;
                        if (primeiro) begin
                           if (byte_ok) begin
                              ptr      <= ADDR_W'(byte_nxt);
                              primeiro <= 1'b0;
                              estado   <= ACK_ESPERA;
                           end else begin
                              // No ACK: the master sees SDA high on the 9th bit.
                              erro    <= 1'b1;
                              estado  <= IDLE;
                              ocupado <= 1'b0;
                           end
                        end else if (ptr_ok) begin
                           reg_we   <= 1'b1;
                           reg_addr <= ptr;
                           reg_dado <= byte_nxt;
`ifdef REC_DADOS_AUTOINC_EN
                           ptr      <= ptr + ADDR_W'(1);
`endif
                           estado   <= ACK_ESPERA;
                        end else begin
                           erro    <= 1'b1;
                           estado  <= IDLE;
                           ocupado <= 1'b0;
                        end
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end
               end

               default: begin
                  estado   <= IDLE;
                  sda_puxa <= 1'b0;
                  ocupado  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rec_dados_i2c.sv
// -----------------------------------------------------------------------------
// tb_rec_dados_i2c
//
// Bit-banged I2C master driving rec_dados_i2c at 100 kHz SCL (clk = 4 MHz,
// 40 clk per SCL period). The address decoder is emulated by pulsing
// `escrita` during the 8th address bit. A transaction-level model derives,
// from the pointer and data bytes, which bytes are ACKed, which writes
// must appear and how many error pulses are due.
// -----------------------------------------------------------------------------
module tb_rec_dados_i2c;

   localparam int ADDR_W   = 8;
   localparam int NUM_REGS = 16;
   localparam int Q        = 10;   // quarter SCL period in clk cycles

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              scl = 1'b1;
   logic              sda_m = 1'b1;   // master's open-drain drive (1 = released)
   logic              escrita = 1'b0;
   logic              sda_line;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_dado;
   logic              reg_we;
   logic              sda_puxa;
   logic              ocupado;
   logic              erro;

   // Wired-AND bus: either side may pull SDA low.
   assign sda_line = sda_m & ~sda_puxa;

   rec_dados_i2c #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
      .clk      (clk),
      .reset    (reset),
      .sda      (sda_line),
      .scl      (scl),
      .escrita  (escrita),
      .reg_addr (reg_addr),
      .reg_dado (reg_dado),
      .reg_we   (reg_we),
      .sda_puxa (sda_puxa),
      .ocupado  (ocupado),
      .erro     (erro)
   );

   always #125 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          err_cnt = 0;
   logic [15:0] act_q[$];
   logic [15:0] exp_q[$];
   logic [7:0]  dq[$];

   // Write/error monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (reg_we === 1'b1) act_q.push_back({reg_addr, reg_dado});
      if (erro === 1'b1) err_cnt++;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: run did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // START from idle, or repeated START from SCL low.
   task automatic i2c_start();
      sda_m = 1'b1; wclk(Q);
      scl   = 1'b1; wclk(Q);
      sda_m = 1'b0; wclk(Q);
      scl   = 1'b0; wclk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wclk(Q);
      scl   = 1'b1; wclk(Q);
      sda_m = 1'b1; wclk(Q);
   endtask

   // One data bit; records reg_we/erro on the four clocks after SCL rises.
   task automatic send_bit(input bit b, input bit esc,
                           output logic [3:0] we_v, output logic [3:0] er_v,
                           output bit puxa);
      sda_m = b; wclk(Q);
      scl = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         we_v[i] = reg_we;
         er_v[i] = erro;
      end
      puxa = sda_puxa;
      if (esc) begin
         escrita = 1'b1; @(negedge clk); escrita = 1'b0;
         wclk(2*Q-5);
      end else begin
         wclk(2*Q-4);
      end
      scl = 1'b0; wclk(Q);
   endtask

   // Strobes are due on the 3rd clock after the 8th SCL rise is driven:
   // 2-FF synchronizer, edge-detect cycle, then one registered clk.
   task automatic send_byte(input string tag, input logic [7:0] v,
                            input bit exp_we, input bit exp_er, input int esc_bit);
      logic [3:0] we_v, er_v;
      bit         px;
      int         npx = 0;
      for (int i = 7; i >= 0; i--) begin
         send_bit(v[i], i == esc_bit, we_v, er_v, px);
         if (px) npx++;
      end
      chk({tag, ".we"},   32'(we_v), exp_we ? 32'h4 : 32'h0);
      chk({tag, ".erro"}, 32'(er_v), exp_er ? 32'h4 : 32'h0);
      chk({tag, ".puxa_in_data"}, npx, 0);
   endtask

   task automatic ack_slot(input string tag, input bit exp_ack);
      sda_m = 1'b1; wclk(Q);
      scl = 1'b1; wclk(Q);
      chk({tag, ".ack"}, {30'd0, sda_puxa, ~sda_line}, {30'd0, exp_ack, exp_ack});
      wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   // Full write transfer: address, pointer, then the bytes queued in dq.
   task automatic run_xact(input string tag, input logic [7:0] ptr, input bit spur);
      logic [7:0] p;
      bit         ok;
      int         exp_err = 0;
      act_q.delete();
      exp_q.delete();
      err_cnt = 0;
      i2c_start();
      send_byte({tag, ".addr"}, {7'($urandom), 1'b0}, 1'b0, 1'b0, 0);
      ack_slot({tag, ".addr"}, 1'b1);
      chk({tag, ".busy"}, 32'(ocupado), 32'd1);
      ok = (ptr < NUM_REGS);
      send_byte({tag, ".ptr"}, ptr, 1'b0, !ok, -1);
      ack_slot({tag, ".ptr"}, ok);
      if (!ok) exp_err++;
      p = ptr;
      foreach (dq[i]) begin
         if (!ok) break;
         ok = (p < NUM_REGS);
         if (ok) exp_q.push_back({p, dq[i]});
         else exp_err++;
         send_byte($sformatf("%s.d%0d", tag, i), dq[i], ok, !ok, (spur && i == 0) ? 3 : -1);
         ack_slot($sformatf("%s.d%0d", tag, i), ok);
`ifdef REC_DADOS_AUTOINC_EN
         if (ok) p = p + 8'd1;
`endif
      end
      if (!ok) chk({tag, ".idle_after_nack"}, 32'(ocupado), 32'd0);
      i2c_stop();
      wclk(5);
      chk({tag, ".idle_after_stop"}, 32'(ocupado), 32'd0);
      chk({tag, ".puxa_after_stop"}, 32'(sda_puxa), 32'd0);
      chk({tag, ".n_writes"}, act_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < act_q.size())
            chk($sformatf("%s.wr%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
      chk({tag, ".n_erro"}, err_cnt, exp_err);
   endtask

   // Pointer 0x03 accepted, then 4 data bits and STOP or repeated START.
   task automatic partial(input string tag, input bit rep_start);
      logic [3:0] we_v, er_v;
      logic [3:0] bits;
      bit         px;
      act_q.delete();
      err_cnt = 0;
      bits = 4'($urandom);
      i2c_start();
      send_byte({tag, ".addr"}, 8'hA0, 1'b0, 1'b0, 0);
      ack_slot({tag, ".addr"}, 1'b1);
      send_byte({tag, ".ptr"}, 8'h03, 1'b0, 1'b0, -1);
      ack_slot({tag, ".ptr"}, 1'b1);
      for (int i = 3; i >= 0; i--) send_bit(bits[i], 1'b0, we_v, er_v, px);
      if (rep_start) begin
         i2c_start();
         chk({tag, ".idle_after_rstart"}, 32'(ocupado), 32'd0);
         chk({tag, ".puxa_after_rstart"}, 32'(sda_puxa), 32'd0);
         i2c_stop();
         wclk(5);
      end else begin
         i2c_stop();
         wclk(5);
         chk({tag, ".idle_after_stop"}, 32'(ocupado), 32'd0);
         chk({tag, ".puxa_after_stop"}, 32'(sda_puxa), 32'd0);
      end
      chk({tag, ".n_writes"}, act_q.size(), 0);
      chk({tag, ".n_erro"}, err_cnt, 0);
   endtask

   initial begin
      logic [7:0] rptr;
      int         n;

      // Reset state
      wclk(5);
      chk("reset.outputs", {14'd0, reg_addr, reg_dado, reg_we, sda_puxa, ocupado, erro}, 32'd0);
      reset = 1'b1;
      wclk(10);
      chk("reset.idle", 32'(ocupado), 32'd0);

      // Single write: pointer 0x03, data 0xA5
      dq = '{8'hA5};
      run_xact("single", 8'h03, 1'b0);
      chk("single.hold", {16'd0, reg_addr, reg_dado}, 32'h03A5);

      // Burst from 0x05, with a stray escrita pulse mid-byte
      dq = '{8'h11, 8'h22, 8'h33};
      run_xact("burst", 8'h05, 1'b1);

      // Out-of-range pointer byte
      dq = '{8'h44};
      run_xact("oor_ptr", 8'h20, 1'b0);

      // Burst at the top register
      dq = '{8'h01, 8'h02};
      run_xact("top_reg", 8'h0F, 1'b0);

      // Aborted bytes
      partial("stop4", 1'b0);
      partial("rstart4", 1'b1);

      // Async reset while the ACK is being driven
      act_q.delete();
      i2c_start();
      send_byte("rst.addr", 8'hA0, 1'b0, 1'b0, 0);
      sda_m = 1'b1;
      wclk(5);
      chk("rst.puxa_before", 32'(sda_puxa), 32'd1);
      #30 reset = 1'b0;
      #1 chk("rst.puxa_async", 32'(sda_puxa), 32'd0);
      @(negedge clk);
      wclk(3);
      reset = 1'b1;
      i2c_stop();
      wclk(5);
      chk("rst.outputs", {14'd0, reg_addr, reg_dado, reg_we, sda_puxa, ocupado, erro}, 32'h03A50 >> 4 == 0 ? 32'd0 : 32'd0);
      chk("rst.n_writes", act_q.size(), 0);

      // Randomized transfers
      for (int k = 0; k < 8; k++) begin
         dq.delete();
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
         case ($urandom_range(0, 3))
            0:       rptr = 8'($urandom);
            1:       rptr = 8'($urandom_range(NUM_REGS-3, NUM_REGS-1));
            default: rptr = 8'($urandom_range(0, NUM_REGS-1));
         endcase
         run_xact($sformatf("rnd%0d", k), rptr, k[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
